// File: rtl/rainbow_duty_gen_if.sv
// Sequencer <-> PWM-stage bundle: period strobe/enable in, duty triplet + hue sector out.
interface rainbow_duty_gen_if #(
  parameter int DUTY_W = 12
);
  logic              frame_tick;
  logic              en;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic              duty_vld;
  logic [2:0]        sector;

  modport master (output frame_tick, en,
                  input  duty_r, duty_g, duty_b, duty_vld, sector);
  modport slave  (input  frame_tick, en,
                  output duty_r, duty_g, duty_b, duty_vld, sector);
endinterface

// File: rtl/rainbow_duty_gen.sv
// Six-sector hue-wheel walker producing registered R/G/B PWM duties, stepped on frame ticks.
// Optional macro RAINBOW_INVERT_EN drives every duty as DUTY_MAX - value (common-anode).
module rainbow_duty_gen #(
  parameter int PERIOD = 2450,
  parameter int DUTY_W = 12,
  parameter int INC    = 49,
  parameter int DIV    = 1
) (
  input  logic               CLK,
  input  logic               RST,
  rainbow_duty_gen_if.slave  bus
);
  localparam int DUTY_MAX = PERIOD - 1;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DUTY_W-1:0] M = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] Z = '0;
`ifdef RAINBOW_INVERT_EN
  localparam logic [2:0][DUTY_W-1:0] RST_DUTY = {Z, M, M};
`else
  localparam logic [2:0][DUTY_W-1:0] RST_DUTY = {M, Z, Z};
`endif

  logic [2:0]              r_sector;
  logic [DUTY_W-1:0]       r_ramp;
  logic [DIV_W-1:0]        r_div_cnt;
  logic [2:0][DUTY_W-1:0]  r_duty;   // [2]=R [1]=G [0]=B
  logic                    r_vld;

  logic                    w_tick, w_div_wrap, w_step;
  logic [DUTY_W:0]         w_sum;
  logic [2:0]              w_sector_nxt;
  logic [DUTY_W-1:0]       w_ramp_nxt;
  logic [2:0][DUTY_W-1:0]  w_map;
  logic [2:0][DUTY_W-1:0]  w_out;

  assign w_tick     = bus.frame_tick & bus.en;
  assign w_div_wrap = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_step     = w_tick & w_div_wrap;
  assign w_sum      = {1'b0, r_ramp} + (DUTY_W+1)'(INC);

  // Last ramp value of a sector is skipped so the next sector's ramp 0 continues the curve.
  always_comb begin
    w_sector_nxt = r_sector;
    w_ramp_nxt   = w_sum[DUTY_W-1:0];
    if (r_sector > 3'd5) begin
      w_sector_nxt = 3'd0;
      w_ramp_nxt   = '0;
    end else if (w_sum >= (DUTY_W+1)'(DUTY_MAX)) begin
      w_ramp_nxt   = '0;
      w_sector_nxt = (r_sector == 3'd5) ? 3'd0 : r_sector + 3'd1;
    end
  end

  // Outputs are mapped from the next state so they land together with the sector update.
  always_comb begin
    w_map = {M, Z, Z};
    case (w_sector_nxt)
      3'd0:    w_map = {M, w_ramp_nxt, Z};
      3'd1:    w_map = {M - w_ramp_nxt, M, Z};
      3'd2:    w_map = {Z, M, w_ramp_nxt};
      3'd3:    w_map = {Z, M - w_ramp_nxt, M};
      3'd4:    w_map = {w_ramp_nxt, Z, M};
      3'd5:    w_map = {M, Z, M - w_ramp_nxt};
      default: w_map = {M, Z, Z};
    endcase
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
`ifdef RAINBOW_INVERT_EN
    assign w_out[ch] = M - w_map[ch];
`else
    assign w_out[ch] = w_map[ch];
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sector  <= 3'd0;
      r_ramp    <= '0;
      r_div_cnt <= '0;
      r_duty    <= RST_DUTY;
      r_vld     <= 1'b0;
    end else begin
      r_vld <= w_step;
      if (w_tick)
        r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      if (w_step) begin
        r_sector <= w_sector_nxt;
        r_ramp   <= w_ramp_nxt;
        r_duty   <= w_out;
      end
    end
  end

  assign bus.duty_r   = r_duty[2];
  assign bus.duty_g   = r_duty[1];
  assign bus.duty_b   = r_duty[0];
  assign bus.duty_vld = r_vld;
  assign bus.sector   = r_sector;
endmodule

// File: tb/tb_rainbow_duty_gen.sv
// Bench for rainbow_duty_gen: cumulative-tick vector table, scoreboard on duty_vld, hand corner cases.
module tb_rainbow_duty_gen;
  localparam int M = 2449;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  rainbow_duty_gen_if #(.DUTY_W(12)) bus  ();
  rainbow_duty_gen_if #(.DUTY_W(12)) bus4 ();

  rainbow_duty_gen #(.PERIOD(2450), .DUTY_W(12), .INC(49), .DIV(1)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  rainbow_duty_gen #(.PERIOD(2450), .DUTY_W(12), .INC(49), .DIV(4)) dut4 (.CLK(CLK), .RST(RST), .bus(bus4));

  typedef struct packed {
    logic [2:0]  sec;
    logic [11:0] r, g, b;
  } obs_t;

  typedef struct {
    int ticks;          // cumulative ticks since reset
    int sec, r, g, b;   // un-inverted channel values
  } vec_t;

  int   n_cmp = 0, n_bad = 0, vld_cnt = 0;
  int   m_sec, m_ramp;
  obs_t sbq[$];

  function automatic logic [11:0] inv(int v);
`ifdef RAINBOW_INVERT_EN
    return 12'(M - v);
`else
    return 12'(v);
`endif
  endfunction

  function automatic obs_t mk(int s, int r, int g, int b);
    obs_t o;
    o.sec = 3'(s); o.r = inv(r); o.g = inv(g); o.b = inv(b);
    return o;
  endfunction

  function automatic obs_t exp_map(int s, int rr);
    case (s)
      0: return mk(0, M, rr, 0);
      1: return mk(1, M - rr, M, 0);
      2: return mk(2, 0, M, rr);
      3: return mk(3, 0, M - rr, M);
      4: return mk(4, rr, 0, M);
      default: return mk(5, M, 0, M - rr);
    endcase
  endfunction

  function automatic obs_t act1();
    return {bus.sector, bus.duty_r, bus.duty_g, bus.duty_b};
  endfunction

  task automatic check(string name, obs_t a, obs_t e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got sec=%0d r=%0d g=%0d b=%0d, want sec=%0d r=%0d g=%0d b=%0d",
               name, a.sec, a.r, a.g, a.b, e.sec, e.r, e.g, e.b);
    end
  endtask

  task automatic check_int(string name, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  // Scoreboard: every duty_vld pulse must match the oldest expected step result.
  always @(negedge CLK) begin
    if (RST === 1'b1 && bus.duty_vld === 1'b1) begin
      vld_cnt++;
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected_vld: got duty_vld=1, want no pending step");
      end else
        check("sb_step", act1(), sbq.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
    bus.frame_tick  = 1'b1;
    bus4.frame_tick = 1'b1;
    if (bus.en) begin
      if (m_ramp + 49 >= M) begin
        m_ramp = 0;
        m_sec  = (m_sec == 5) ? 0 : m_sec + 1;
      end else
        m_ramp = m_ramp + 49;
      sbq.push_back(exp_map(m_sec, m_ramp));
    end
    @(posedge CLK); #1;
    bus.frame_tick  = 1'b0;
    bus4.frame_tick = 1'b0;
  endtask

  task automatic do_reset(bit checked);
    @(negedge CLK); #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      bus.frame_tick  = ~bus.frame_tick;
      bus4.frame_tick = bus.frame_tick;
      @(negedge CLK);
      if (checked) begin
        check("reset_hold", act1(), mk(0, M, 0, 0));
        check_int("reset_vld", int'(bus.duty_vld), 0);
      end
    end
    @(posedge CLK); #1;
    bus.frame_tick = 1'b0; bus4.frame_tick = 1'b0;
    RST = 1'b1;
    m_sec = 0; m_ramp = 0; vld_cnt = 0;
    sbq.delete();
  endtask

  vec_t tbl[6];
  obs_t snap;
  int   done;

  initial begin
    tbl[0] = '{1,   0, M,    49,   0};
    tbl[1] = '{50,  1, M,    M,    0};
    tbl[2] = '{51,  1, 2400, M,    0};
    tbl[3] = '{150, 3, 0,    M,    M};
    tbl[4] = '{175, 3, 0,    1224, M};
    tbl[5] = '{300, 0, M,    0,    0};

    RST = 1'b0;
    bus.frame_tick = 1'b0; bus4.frame_tick = 1'b0;
    bus.en = 1'b1; bus4.en = 1'b1;
    m_sec = 0; m_ramp = 0;
    do_reset(1'b1);

    // Single step on DIV=1; divided instance must wait for its 4th tick.
    tick();
    @(negedge CLK);
    check("single_step", act1(), mk(0, M, 49, 0));
    check_int("single_vld_hi", int'(bus.duty_vld), 1);
    check_int("div4_g_t1", int'(bus4.duty_g), int'(inv(0)));
    @(negedge CLK);
    check_int("single_vld_lo", int'(bus.duty_vld), 0);
    for (int t = 2; t <= 4; t++) begin
      tick();
      @(negedge CLK);
      check_int($sformatf("div4_g_t%0d", t), int'(bus4.duty_g), int'(inv(t == 4 ? 49 : 0)));
      check_int($sformatf("div4_vld_t%0d", t), int'(bus4.duty_vld), (t == 4) ? 1 : 0);
    end

    do_reset(1'b0);
    done = 0;
    foreach (tbl[i]) begin
      while (done < tbl[i].ticks) begin
        tick();
        done++;
      end
      @(negedge CLK);
      check($sformatf("vec%0d_t%0d", i, tbl[i].ticks), act1(),
            mk(tbl[i].sec, tbl[i].r, tbl[i].g, tbl[i].b));
    end
    #1;
    check_int("wrap_vld_count", vld_cnt, 300);

    // Enable low freezes everything; reassert resumes without restart.
    tick();
    @(negedge CLK); #1;
    snap = act1();
    bus.en = 1'b0; bus4.en = 1'b0;
    vld_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge CLK); #1;
    check("en_low_hold", act1(), snap);
    check_int("en_low_vld", vld_cnt, 0);
    bus.en = 1'b1; bus4.en = 1'b1;
    tick();
    @(negedge CLK);
    check("en_resume", act1(), mk(0, M, 98, 0));

    // Async reset mid-way through sector 3, away from any clock edge.
    while (!(m_sec == 3 && m_ramp > 0)) tick();
    @(negedge CLK); #2;
    RST = 1'b0;
    #1;
    check("mid_reset", act1(), mk(0, M, 0, 0));
    check_int("mid_reset_vld", int'(bus.duty_vld), 0);
    do_reset(1'b0);
    @(negedge CLK);
    check("post_reset", act1(), mk(0, M, 0, 0));
    check_int("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rainbow_duty_gen.md
# rainbow_duty_gen

Upstream colour sequencer for the RGB PWM stage. It walks a six-sector hue wheel and produces three duty values (R, G, B), one per PWM channel. Each PWM channel reports the end of its period with `frame_tick`. Duty values change only on that tick, so every PWM period compares against a stable value.

## Interface
Parameters:
- `PERIOD`, 2450 — PWM period in CLK cycles; must equal the downstream PWM period. `DUTY_MAX = PERIOD-1`.
- `DUTY_W`, 12 — duty output width; must satisfy `2^DUTY_W > DUTY_MAX`.
- `INC`, 49 — ramp increment per step; `1 <= INC <= DUTY_MAX`.
- `DIV`, 1 — number of frame_ticks per step; `DIV >= 1`.

Ports:
- `CLK` in 1 — clock.
- `RST` in 1 — reset, asynchronous, active-low.
- `frame_tick` in 1 — PWM period-end strobe; every cycle sampled high counts as one tick.
- `en` in 1 — run enable; low freezes all state.
- `duty_r`, `duty_g`, `duty_b` out DUTY_W — registered duty values, range 0..DUTY_MAX.
- `duty_vld` out 1 — one-cycle pulse in the cycle the duty outputs change.
- `sector` out 3 — current hue sector, 0..5.

## Operation
- State:
  - `sector` (0..5).
  - `ramp` (DUTY_W bits, 0..DUTY_MAX).
  - `div_cnt` (0..DIV-1).
- Tick accepted = `frame_tick && en`.
- On an accepted tick:
  - If `div_cnt == DIV-1`: `div_cnt <= 0` and a step event fires.
  - Otherwise: `div_cnt <= div_cnt+1`.
- Step event:
  - If `ramp + INC >= DUTY_MAX`: `ramp <= 0` and `sector <= (sector==5) ? 0 : sector+1`.
  - Otherwise: `ramp <= ramp + INC`.
  - The sum is computed at DUTY_W+1 bits, so there is no overflow.
- Channel mapping (M = DUTY_MAX, r = ramp):
  - S0: R=M, G=r, B=0
  - S1: R=M-r, G=M, B=0
  - S2: R=0, G=M, B=r
  - S3: R=0, G=M-r, B=M
  - S4: R=r, G=0, B=M
  - S5: R=M, G=0, B=M-r
- Sector boundaries are continuous. The last ramp value of a sector is skipped, and the next sector's ramp-0 values take its place.
- `sector` values 6 and 7 are unreachable. If either is ever loaded, the next step event forces sector 0 and ramp 0.
- `en` low: tick ignored, `div_cnt`/`ramp`/`sector`/outputs hold. Reasserting `en` resumes from the held state with no restart.

## Timing
- Reset (async assert, RST low): `sector`=0, `ramp`=0, `div_cnt`=0, `duty_r`=DUTY_MAX, `duty_g`=0, `duty_b`=0, `duty_vld`=0.
- A reset asserted mid-operation takes effect immediately, with no completion of any pending step.
- Latency: a step event in cycle N (frame_tick high) updates `duty_*`, `sector` and `duty_vld`=1 in cycle N+1. `duty_vld` returns to 0 in N+2 unless another step event fires in N+1.
- All outputs are registered. There is no combinational path from the inputs to the outputs.
- `frame_tick` held high k cycles counts as k ticks. The downstream PWM is required to deliver single-cycle strobes.
- One full colour cycle = 6 × ceil(DUTY_MAX/INC) × DIV frame_ticks. With defaults: 6 × 50 × 1 = 300 ticks.

## Configuration
- `RAINBOW_INVERT_EN` defined: each duty output is driven as `DUTY_MAX - value`, for common-anode LEDs and the downstream stage's active-low output. Reset values become R=0, G=DUTY_MAX, B=DUTY_MAX.
- `duty_vld` timing and `sector` are unchanged by the macro.
- Not defined: outputs are the mapping above, unmodified.

## Test plan
- Reset: hold RST low with `frame_tick` toggling -> `duty_r`=2449, `duty_g`=0, `duty_b`=0, `sector`=0, `duty_vld`=0. These values hold throughout reset.
- Single step: `en`=1, one frame_tick at cycle N -> at N+1, `duty_g`=49 and `duty_vld`=1 for exactly one cycle; R/B unchanged.
- Sector advance: 50 ticks from reset -> `sector`=1, R=2449, G=2449, B=0. The 51st tick gives R=2400.
- Full wrap: 300 ticks -> `sector`=0, R=2449, G=0, B=0; `duty_vld` pulsed 300 times.
- Enable/divider:
  - `en`=0 with 10 ticks -> no output change, no `duty_vld`.
  - DIV=4 -> `duty_g` reaches 49 only on the 4th tick.
- Mid-operation reset with `RAINBOW_INVERT_EN` defined: run to sector 3, assert RST -> outputs immediately R=0, G=2449, B=2449, `sector`=0.
